axis_master_tx: RTL and testbench

AXI4-Stream master (transmit) interface of the FFT core. After a transform completes, it reads the result memory sample by sample and streams each complex sample out as one AXI beat. A small FIFO and a registered output stage absorb the one-cycle memory read latency and downstream back-pressure. It is the output-side counterpart of the slave receive interface and shares its control handshake with the compute block.

---
 rtl/axi_stream_pckg.sv | 21 ++
 rtl/axis_tx_fifo.sv | 65 ++++++
 rtl/axis_master_tx.sv | 151 +++++++++++++++
 tb/tb_axis_master_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pckg.sv
// Shared types and constants for the FFT AXI4-Stream interfaces: transmit
// FSM states, default stream/FIFO widths and an address bit-reversal helper.
package axi_stream_pckg;

   localparam int M_TDATA_WDT     = 32;
   localparam int M_FIFO_ADDR_WDT = 2;

   typedef enum logic [1:0] {
      M_IDLE,
      M_RD,
      M_DRAIN
   } m_tx_state;

   // Reverses the low w bits of v; bits above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r >> (32 - w);
   endfunction

endpackage

// File: rtl/axis_tx_fifo.sv
// Count-based synchronous FIFO between the result-memory read port and the
// AXI output register; pointers wrap naturally, depth is 2^ADDR_WDT.
module axis_tx_fifo #(
   parameter int DATA_WDT = 32,
   parameter int ADDR_WDT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [DATA_WDT-1:0] din_i,
   output logic [DATA_WDT-1:0] dout_o,
   output logic [ADDR_WDT:0]   count_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int DEPTH = 1 << ADDR_WDT;

   logic [DATA_WDT-1:0] mem_q [DEPTH];
   logic [ADDR_WDT-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WDT-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WDT:0]   cnt_q, cnt_d;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_i) wr_ptr_d = wr_ptr_q + ADDR_WDT'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + ADDR_WDT'(1);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + (ADDR_WDT+1)'(1);
         2'b01:   cnt_d = cnt_q - (ADDR_WDT+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; the count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;
   assign full_o  = (cnt_q == (ADDR_WDT+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);

   a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
   a_no_pop_when_empty:  assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/axis_master_tx.sv
// AXI4-Stream transmit side of the FFT core: reads the result memory and streams
// one {re, im} beat per sample. Define M_AXIS_BITREV_EN to read in bit-reversed order.
module axis_master_tx #(
   parameter int FFT_SIZE_LOG2   = 10,
   parameter int SAMPLE_WDT      = 16,
   parameter int M_TDATA_WDT     = axi_stream_pckg::M_TDATA_WDT,
   parameter int M_FIFO_ADDR_WDT = axi_stream_pckg::M_FIFO_ADDR_WDT
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [M_TDATA_WDT-1:0]   M_AXIS_TDATA,
   output logic                     M_AXIS_TVALID,
   output logic                     M_AXIS_TLAST,
   input  logic                     M_AXIS_TREADY,
   output logic [FFT_SIZE_LOG2-1:0] m_axis_if_addr,
   output logic                     m_axis_if_rd_en,
   input  logic [SAMPLE_WDT-1:0]    data_re_0_out,
   input  logic [SAMPLE_WDT-1:0]    data_im_0_out,
   input  logic                     tx_start,
   input  logic                     s_axis_if_busy,
   output logic                     m_axis_if_busy,
   output logic                     tx_done
);

   import axi_stream_pckg::*;

   localparam int FIFO_DEPTH = 1 << M_FIFO_ADDR_WDT;
   localparam int CW         = M_FIFO_ADDR_WDT + 2;
   localparam logic [FFT_SIZE_LOG2-1:0] LAST_IDX = '1;

   m_tx_state                state_q, state_d;
   logic [FFT_SIZE_LOG2-1:0] rd_idx_q, rd_idx_d;
   logic [FFT_SIZE_LOG2-1:0] tx_idx_q, tx_idx_d;
   logic [FFT_SIZE_LOG2-1:0] ld_idx;
   logic                     inflight_q, inflight_d;
   logic                     tvalid_q, tvalid_d;
   logic                     tlast_q, tlast_d;
   logic                     tx_done_q, tx_done_d;
   logic [M_TDATA_WDT-1:0]   tdata_q, tdata_d;

   logic                     rd_en, rd_credit, handshake, load;
   logic [CW-1:0]            occ, lim;
   logic [M_FIFO_ADDR_WDT:0] fifo_cnt;
   logic [M_TDATA_WDT-1:0]   fifo_dout;
   logic                     fifo_full, fifo_empty;

   axis_tx_fifo #(
      .DATA_WDT (M_TDATA_WDT),
      .ADDR_WDT (M_FIFO_ADDR_WDT)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .pop_i   (load),
      .din_i   ({data_re_0_out, data_im_0_out}),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign handshake = tvalid_q & M_AXIS_TREADY;
   assign load      = !fifo_empty & (!tvalid_q | M_AXIS_TREADY);

   // Credit: queued + in-flight samples, less the one leaving now, must stay below depth.
   assign occ       = CW'(fifo_cnt) + CW'(inflight_q);
   assign lim       = CW'(FIFO_DEPTH) + CW'(load);
   assign rd_credit = occ < lim;
   assign rd_en     = (state_q == M_RD) & rd_credit;

   // A load while TVALID is high always coincides with a handshake, so the
   // loaded sample is one past the accepted count.
   assign ld_idx = tx_idx_q + FFT_SIZE_LOG2'(tvalid_q);

   always_comb begin
      state_d   = state_q;
      tx_done_d = 1'b0;
      case (state_q)
         M_IDLE:  if (tx_start && !s_axis_if_busy) state_d = M_RD;
         M_RD:    if (rd_en && rd_idx_q == LAST_IDX) state_d = M_DRAIN;
         M_DRAIN: if (handshake && tlast_q) begin
            state_d   = M_IDLE;
            tx_done_d = 1'b1;
         end
         default: state_d = M_IDLE;
      endcase
   end

   always_comb begin
      rd_idx_d   = rd_idx_q;
      tx_idx_d   = tx_idx_q;
      tdata_d    = tdata_q;
      tlast_d    = tlast_q;
      tvalid_d   = tvalid_q;
      inflight_d = rd_en;
      if (state_q == M_IDLE) begin
         rd_idx_d = '0;
         tx_idx_d = '0;
      end else begin
         if (rd_en)     rd_idx_d = rd_idx_q + FFT_SIZE_LOG2'(1);
         if (handshake) tx_idx_d = tx_idx_q + FFT_SIZE_LOG2'(1);
      end
      if (load) begin
         tdata_d  = fifo_dout;
         tlast_d  = (ld_idx == LAST_IDX);
         tvalid_d = 1'b1;
      end else if (handshake) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= M_IDLE;
         rd_idx_q   <= '0;
         tx_idx_q   <= '0;
         inflight_q <= 1'b0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_idx_q   <= rd_idx_d;
         tx_idx_q   <= tx_idx_d;
         inflight_q <= inflight_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tdata_q    <= tdata_d;
         tx_done_q  <= tx_done_d;
      end
   end

`ifdef M_AXIS_BITREV_EN
   assign m_axis_if_addr = FFT_SIZE_LOG2'(bitrev(32'(rd_idx_q), FFT_SIZE_LOG2));
`else
   assign m_axis_if_addr = rd_idx_q;
`endif

   assign m_axis_if_rd_en = rd_en;
   assign m_axis_if_busy  = (state_q != M_IDLE);
   assign tx_done         = tx_done_q;
   assign M_AXIS_TDATA    = tdata_q;
   assign M_AXIS_TVALID   = tvalid_q;
   assign M_AXIS_TLAST    = tlast_q;

   a_axis_hold: assert property (@(posedge clk) disable iff (rst)
      (tvalid_q && !M_AXIS_TREADY) |=> (tvalid_q && $stable(tdata_q) && $stable(tlast_q)));
   a_credit_ok: assert property (@(posedge clk) disable iff (rst) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_axis_master_tx.sv
// Directed bench for axis_master_tx: an 8-sample instance for the timing,
// back-pressure, start-filter and reset scenarios, a 1024-sample one for random TREADY.
module tb_axis_master_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // 8-sample instance
   logic [31:0] tdata_s;
   logic        tvalid_s, tlast_s, rd_en_s, busy_s, done_s;
   logic        tready_s = 1'b1, tx_start_s = 1'b0, s_busy_s = 1'b0;
   logic [2:0]  addr_s;
   logic [15:0] re_s = '0, im_s = '0;

   // 1024-sample instance
   logic [31:0] tdata_l;
   logic        tvalid_l, tlast_l, rd_en_l, busy_l, done_l;
   logic        tready_l = 1'b1, tx_start_l = 1'b0, s_busy_l = 1'b0;
   logic [9:0]  addr_l;
   logic [15:0] re_l = '0, im_l = '0;

   int errors = 0;
   int checks = 0;

   axis_master_tx #(.FFT_SIZE_LOG2(3), .SAMPLE_WDT(16), .M_TDATA_WDT(32), .M_FIFO_ADDR_WDT(2)) dut_s (
      .clk(clk), .rst(rst),
      .M_AXIS_TDATA(tdata_s), .M_AXIS_TVALID(tvalid_s), .M_AXIS_TLAST(tlast_s), .M_AXIS_TREADY(tready_s),
      .m_axis_if_addr(addr_s), .m_axis_if_rd_en(rd_en_s),
      .data_re_0_out(re_s), .data_im_0_out(im_s),
      .tx_start(tx_start_s), .s_axis_if_busy(s_busy_s), .m_axis_if_busy(busy_s), .tx_done(done_s)
   );

   axis_master_tx #(.FFT_SIZE_LOG2(10), .SAMPLE_WDT(16), .M_TDATA_WDT(32), .M_FIFO_ADDR_WDT(2)) dut_l (
      .clk(clk), .rst(rst),
      .M_AXIS_TDATA(tdata_l), .M_AXIS_TVALID(tvalid_l), .M_AXIS_TLAST(tlast_l), .M_AXIS_TREADY(tready_l),
      .m_axis_if_addr(addr_l), .m_axis_if_rd_en(rd_en_l),
      .data_re_0_out(re_l), .data_im_0_out(im_l),
      .tx_start(tx_start_l), .s_axis_if_busy(s_busy_l), .m_axis_if_busy(busy_l), .tx_done(done_l)
   );

   // Result memories: word k = {k, ~k}, one cycle read latency.
   always @(posedge clk) begin
      if (rd_en_s) begin
         re_s <= {13'd0, addr_s};
         im_s <= ~{13'd0, addr_s};
      end
      if (rd_en_l) begin
         re_l <= {6'd0, addr_l};
         im_l <= ~{6'd0, addr_l};
      end
   end

   function automatic logic [31:0] word(input int k);
      logic [15:0] r;
      r = k[15:0];
      return {r, ~r};
   endfunction

   // Memory address holding the j-th streamed sample.
   function automatic int exp_addr(input int j, input int w);
      int r;
`ifdef M_AXIS_BITREV_EN
      r = 0;
      for (int i = 0; i < w; i++) if (j[i]) r = r | (1 << (w - 1 - i));
`else
      r = j & ((1 << w) - 1);
`endif
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++; if (tvalid_s !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", tvalid_s); end
      checks++; if (tlast_s !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b want 0", tlast_s); end
      checks++; if (tdata_s !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", tdata_s); end
      checks++; if (rd_en_s !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b want 0", rd_en_s); end
      checks++; if (addr_s !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_s); end
      checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_s); end
      checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_s); end
      checks++; if (tvalid_l !== 1'b0) begin errors++; $display("FAIL reset_tvalid_l: got %0b want 0", tvalid_l); end
      rst = 1'b0;
      tick();
   endtask

   // TREADY held high: beats 0..7 in cycles 4..11, tx_done in cycle 12.
   task automatic test_basic();
      int beat = 0, rd = 0, done_cyc = -1, done_cnt = 0;
      tready_s = 1'b1;
      tx_start_s = 1'b1;
      tick();
      tx_start_s = 1'b0;
      checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %0b want 1", busy_s); end
      checks++; if (rd_en_s !== 1'b1) begin errors++; $display("FAIL basic_first_rd: got %0b want 1", rd_en_s); end
      checks++; if (addr_s !== 3'd0) begin errors++; $display("FAIL basic_first_addr: got %0d want 0", addr_s); end
      for (int cyc = 1; cyc <= 14; cyc++) begin
         if (rd_en_s) begin
            checks++; if (int'(addr_s) !== exp_addr(rd, 3)) begin errors++; $display("FAIL basic_addr[%0d]: got %0d want %0d", rd, addr_s, exp_addr(rd, 3)); end
            rd++;
         end
         if (tvalid_s) begin
            checks++; if (cyc !== 4 + beat) begin errors++; $display("FAIL basic_beat_cycle[%0d]: got %0d want %0d", beat, cyc, 4 + beat); end
            checks++; if (tdata_s !== word(exp_addr(beat, 3))) begin errors++; $display("FAIL basic_tdata[%0d]: got %h want %h", beat, tdata_s, word(exp_addr(beat, 3))); end
            checks++; if (tlast_s !== (beat == 7)) begin errors++; $display("FAIL basic_tlast[%0d]: got %0b want %0b", beat, tlast_s, beat == 7); end
            beat++;
         end
         if (done_s) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (cyc == 12) begin
            checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %0b want 0", busy_s); end
         end
         tick();
      end
      checks++; if (beat !== 8) begin errors++; $display("FAIL basic_beats: got %0d want 8", beat); end
      checks++; if (rd !== 8) begin errors++; $display("FAIL basic_reads: got %0d want 8", rd); end
      checks++; if (done_cyc !== 12) begin errors++; $display("FAIL basic_done_cycle: got %0d want 12", done_cyc); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
   endtask

   // TREADY low for 10 cycles while beat 2 is presented.
   task automatic test_backpressure();
      int beat = 0, rd = 0, stall_left = -1, stall_reads = 0, held_bad = 0;
      int gaps = 0, max_occ = 0, done_cnt = 0;
      logic [31:0] held = '0;
      tready_s = 1'b1;
      tx_start_s = 1'b1;
      tick();
      tx_start_s = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (stall_left < 0 && beat == 2 && tvalid_s) begin
            stall_left = 10;
            held = tdata_s;
         end
         if (stall_left > 0) begin
            tready_s = 1'b0;
            if (tvalid_s !== 1'b1 || tdata_s !== held) held_bad++;
            if (rd_en_s) stall_reads++;
            stall_left--;
         end else begin
            tready_s = 1'b1;
            if (stall_left == 0 && beat < 8 && !tvalid_s) gaps++;
         end
         if (rd_en_s) rd++;
         if (tvalid_s && tready_s) begin
            checks++; if (tdata_s !== word(exp_addr(beat, 3))) begin errors++; $display("FAIL bp_tdata[%0d]: got %h want %h", beat, tdata_s, word(exp_addr(beat, 3))); end
            beat++;
         end
         if (rd - beat > max_occ) max_occ = rd - beat;
         if (done_s) done_cnt++;
         tick();
      end
      tready_s = 1'b1;
      checks++; if (held !== word(exp_addr(2, 3))) begin errors++; $display("FAIL bp_held_value: got %h want %h", held, word(exp_addr(2, 3))); end
      checks++; if (held_bad !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles want 0", held_bad); end
      checks++; if (stall_reads > 5) begin errors++; $display("FAIL bp_stall_reads: got %0d want <=5", stall_reads); end
      checks++; if (max_occ !== 5) begin errors++; $display("FAIL bp_max_held: got %0d want 5", max_occ); end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL bp_resume_gaps: got %0d want 0", gaps); end
      checks++; if (beat !== 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", beat); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
   endtask

   // tx_start blocked by s_axis_if_busy, then repeated mid-frame and during drain.
   task automatic test_start_ignored();
      int stray = 0, beat = 0, rd = 0, done_cnt = 0, after_done = 0;
      s_busy_s = 1'b1;
      tx_start_s = 1'b1;
      tick();
      tx_start_s = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         if (busy_s || rd_en_s) stray++;
         tick();
      end
      s_busy_s = 1'b0;
      checks++; if (stray !== 0) begin errors++; $display("FAIL ign_busy_start: got %0d active cycles want 0", stray); end
      tx_start_s = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 22; cyc++) begin
         tx_start_s = (cyc == 5 || cyc == 10);
         if (rd_en_s) rd++;
         if (tvalid_s) begin
            checks++; if (tdata_s !== word(exp_addr(beat, 3))) begin errors++; $display("FAIL ign_tdata[%0d]: got %h want %h", beat, tdata_s, word(exp_addr(beat, 3))); end
            beat++;
         end
         if (done_cnt > 0 && (busy_s || rd_en_s || tvalid_s)) after_done++;
         if (done_s) done_cnt++;
         tick();
      end
      tx_start_s = 1'b0;
      checks++; if (rd !== 8) begin errors++; $display("FAIL ign_reads: got %0d want 8", rd); end
      checks++; if (beat !== 8) begin errors++; $display("FAIL ign_beats: got %0d want 8", beat); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
      checks++; if (after_done !== 0) begin errors++; $display("FAIL ign_second_frame: got %0d active cycles want 0", after_done); end
   endtask

   // Reset while beat 5 is presented, then a clean restart from address 0.
   task automatic test_reset_mid();
      int beat = 0, stray = 0, done_cnt = 0;
      bit found = 1'b0;
      tready_s = 1'b1;
      tx_start_s = 1'b1;
      tick();
      tx_start_s = 1'b0;
      for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
         if (tvalid_s && beat == 5) found = 1'b1;
         else begin
            if (tvalid_s) beat++;
            tick();
         end
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL rstmid_reach_beat5: got %0b want 1", found); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (tvalid_s !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %0b want 0", tvalid_s); end
      checks++; if (tlast_s !== 1'b0) begin errors++; $display("FAIL rstmid_tlast: got %0b want 0", tlast_s); end
      checks++; if (tdata_s !== 32'h0) begin errors++; $display("FAIL rstmid_tdata: got %h want 0", tdata_s); end
      checks++; if (rd_en_s !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %0b want 0", rd_en_s); end
      checks++; if (addr_s !== 3'd0) begin errors++; $display("FAIL rstmid_addr: got %0d want 0", addr_s); end
      checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", busy_s); end
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (tvalid_s || done_s || busy_s || rd_en_s) stray++;
         tick();
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_dropped: got %0d active cycles want 0", stray); end
      tx_start_s = 1'b1;
      tick();
      tx_start_s = 1'b0;
      checks++; if (rd_en_s !== 1'b1) begin errors++; $display("FAIL rstmid_restart_rd: got %0b want 1", rd_en_s); end
      checks++; if (int'(addr_s) !== exp_addr(0, 3)) begin errors++; $display("FAIL rstmid_restart_addr: got %0d want %0d", addr_s, exp_addr(0, 3)); end
      beat = 0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         if (tvalid_s) begin
            checks++; if (tdata_s !== word(exp_addr(beat, 3))) begin errors++; $display("FAIL rstmid_tdata[%0d]: got %h want %h", beat, tdata_s, word(exp_addr(beat, 3))); end
            beat++;
         end
         if (done_s) done_cnt++;
         tick();
      end
      checks++; if (beat !== 8) begin errors++; $display("FAIL rstmid_beats: got %0d want 8", beat); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d want 1", done_cnt); end
   endtask

   // 1024-sample frame with TREADY toggling at random.
   task automatic test_random();
      int beat = 0, data_bad = 0, first_bad = -1, hold_bad = 0;
      int tlast_cnt = 0, tlast_bad = 0, done_cnt = 0, post = -1;
      bit fin = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
      logic [31:0] prev_data = '0;
      tx_start_l = 1'b1;
      tick();
      tx_start_l = 1'b0;
      for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
         tready_l = 1'($urandom_range(0, 1));
         if (prev_stall && (tvalid_l !== 1'b1 || tdata_l !== prev_data || tlast_l !== prev_last)) hold_bad++;
         if (tvalid_l && tready_l) begin
            if (tdata_l !== word(exp_addr(beat, 10))) begin
               data_bad++;
               if (first_bad < 0) first_bad = beat;
            end
            if (tlast_l) begin
               tlast_cnt++;
               if (beat != 1023) tlast_bad++;
            end
            beat++;
         end
         prev_stall = tvalid_l && !tready_l;
         prev_data  = tdata_l;
         prev_last  = tlast_l;
         if (done_l) begin
            done_cnt++;
            if (post < 0) post = 0;
         end
         if (post >= 0) begin
            post++;
            if (post > 5) fin = 1'b1;
         end
         tick();
      end
      tready_l = 1'b1;
      checks++; if (fin !== 1'b1) begin errors++; $display("FAIL rand_timeout: got %0b want 1 (frame completed)", fin); end
      checks++; if (beat !== 1024) begin errors++; $display("FAIL rand_beats: got %0d want 1024", beat); end
      checks++; if (data_bad !== 0) begin errors++; $display("FAIL rand_data: got %0d bad beats (first %0d) want 0", data_bad, first_bad); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL rand_hold: got %0d unstable stalls want 0", hold_bad); end
      checks++; if (tlast_cnt !== 1) begin errors++; $display("FAIL rand_tlast_count: got %0d want 1", tlast_cnt); end
      checks++; if (tlast_bad !== 0) begin errors++; $display("FAIL rand_tlast_pos: got %0d misplaced want 0", tlast_bad); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_done_count: got %0d want 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
